uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side byte buffer placed directly downstream of the UART receiver.
- Captures each byte the receiver presents with its one-cycle done pulse and stores it in a DEPTH-entry first-word-fall-through FIFO.
- Hands bytes to the consumer over a valid/ready handshake.
- Reports occupancy, a sticky overflow flag and a saturating count of dropped bytes, so that firmware or a parser never loses framing silently.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two and at least 2.
- ADDR_W, 4, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; release is synchronous to clk.
- rx_data  input  8  byte from the UART receiver; valid only in a cycle where rx_done=1.
- rx_done  input  1  write strobe; every cycle it is high is one write request.
- rd_data  output  8  byte at the head of the FIFO; meaningful only while rd_valid=1.
- rd_valid  output  1  FIFO holds at least one byte.
- rd_ready  input  1  consumer accepts the head byte when rd_valid=1.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky flag: a byte was dropped.
- clr_overflow  input  1  synchronous clear for overflow and drop_cnt.
- drop_cnt  output  8  number of dropped bytes; saturates at 255.

Behaviour:
- Reset values: rd_valid=0, count=0, full=0, empty=1, overflow=0, drop_cnt=0. rd_data has no defined reset value, but the pointers are reset. Memory contents are not reset.
- Storage: memory mem[DEPTH] of 8 bits, write pointer wr_ptr and read pointer rd_ptr, each ADDR_W bits. Pointers wrap DEPTH-1 → 0 by natural modulo; there is no separate wrap bit because count disambiguates full from empty.
- Pop: pop = rd_valid & rd_ready. On the edge, rd_ptr advances by 1.
- rd_data: driven combinationally as mem[rd_ptr] (first-word-fall-through).
- Push: push = rx_done & (~full | pop). On the edge, mem[wr_ptr] <= rx_data and wr_ptr advances by 1.
- Count update per edge:
  - push without pop: +1
  - pop without push: -1
  - both or neither: unchanged
- Flags: full, empty and rd_valid are derived from the registered count; rd_valid = ~empty.
- Write-to-read latency: a byte pushed at edge N appears with rd_valid=1 in the cycle after edge N. There is no same-cycle bypass; if the FIFO is empty and rx_done=1 with rd_ready=1, only the push happens.
- Full and simultaneous pop: when full=1 and rx_done=1 in the same cycle as a pop, the push is accepted, count stays DEPTH, and no drop occurs.
- Drop: when rx_done=1 with full=1 and no pop:
  - rx_data is discarded; mem and pointers are unchanged.
  - overflow <= 1.
  - drop_cnt <= drop_cnt+1, holding at 255.
- clr_overflow:
  - Clears overflow and drop_cnt to 0 on the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_cnt=1.
- Empty pop: rd_ready while empty is ignored; pointers and count are unchanged.
- Reset mid-operation: any contents are discarded and the FIFO returns to the reset values. A byte presented in the same cycle rst is asserted is lost.
- No combinational path from rx_done or rd_ready to any output other than via registered state; rd_data depends only on mem and rd_ptr.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 on separate rx_done pulses with rd_ready=0 → count=3, rd_valid=1, rd_data=0x41. Then hold rd_ready=1 for 3 cycles → rd_data reads 0x41, 0x42, 0x43 in order, then empty=1 and count=0.
- Push 16 bytes 0x00..0x0F, then push 0xAA with rd_ready=0 → full=1, overflow=1, drop_cnt=1, count=16. Draining yields 0x00..0x0F, and 0xAA never appears.
- While full, pulse rx_done=1 with 0x55 and rd_ready=1 in the same cycle → count stays 16, overflow stays 0. After a full drain, the last byte read is 0x55.
- Push and pop continuously for 40 bytes with an incrementing pattern → output order is exact across two pointer wraps, and count never exceeds 1.
- Force 300 drops while full → drop_cnt=255. Then assert clr_overflow and a drop in the same cycle → overflow=1, drop_cnt=1. Then clr_overflow alone → overflow=0, drop_cnt=0.
- Fill 5 bytes, then pull rst low asynchronously mid-cycle → empty=1, count=0 and rd_valid=0 immediately. After release, a push of 0x77 reads back as the first byte.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side byte buffer that sits directly behind the UART receiver.
//   Each rx_done pulse is one write request.  Bytes are held in a DEPTH-entry
//   first-word-fall-through FIFO and handed to the consumer over valid/ready.
//   When a byte arrives while the FIFO is full and nothing is being popped,
//   it is dropped.  A sticky overflow flag and a saturating drop counter
//   record the loss so the consumer never loses framing silently.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   rx_data      byte from the receiver, sampled when rx_done=1
//   rx_done      write strobe, one request per high cycle
//   rd_data      head byte, valid only while rd_valid=1
//   rd_valid     FIFO holds at least one byte
//   rd_ready     consumer accepts the head byte
//   count        occupancy, 0..DEPTH
//   full, empty  occupancy flags
//   overflow     sticky: at least one byte was dropped
//   clr_overflow synchronous clear of overflow and drop_cnt
//   drop_cnt     dropped-byte count, saturates at 255
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic [7:0]        drop_cnt
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic push, pop, drop;

    // Flags come only from the registered count, so there is no
    // combinational path from rx_done or rd_ready to any output.
    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign rd_valid = ~empty;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign rd_data  = mem[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign pop  = rd_valid & rd_ready;
    assign push = rx_done & (~full | pop);
    assign drop = rx_done & full & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear wins: the clear happens
        // first, then the new drop is counted.
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_overflow)
                drop_cnt_d = 8'd1;
            else if (drop_cnt_q != 8'hFF)
                drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= rx_data;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_overflow = 1'b0;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of bytes plus the loss bookkeeping.
    byte unsigned q[$];
    bit           m_ovf = 1'b0;
    int           m_dcnt = 0;
    byte unsigned last_pop;
    bit           popped;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .count(count), .full(full), .empty(empty), .overflow(overflow),
        .clr_overflow(clr_overflow), .drop_cnt(drop_cnt)
    );

    // Drive one cycle of inputs, advance the model by the FIFO rules, then
    // return 1 time unit after the edge so outputs are sampled away from it.
    task automatic step(input bit rxd, input byte unsigned d, input bit rdy, input bit clr);
        int  sz;
        bit  mfull, mpop, mpush, mdrop;
        rx_done = rxd; rx_data = d; rd_ready = rdy; clr_overflow = clr;
        sz    = q.size();
        mfull = (sz == 16);
        mpop  = (sz > 0) && rdy;
        mpush = rxd && (!mfull || mpop);
        mdrop = rxd && mfull && !mpop;
        @(posedge clk);
        popped = mpop;
        if (mpop)  last_pop = q.pop_front();
        if (mpush) q.push_back(d);
        if (mdrop) begin
            m_ovf  = 1'b1;
            m_dcnt = clr ? 1 : ((m_dcnt >= 255) ? 255 : m_dcnt + 1);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_dcnt = 0;
        end
        #1;
        rx_done = 1'b0; rd_ready = 1'b0; clr_overflow = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #12;
        total++; if (count !== 5'd0)  begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1)  begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
        total++; if (full !== 1'b0)   begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_dcnt got=%0d exp=0", drop_cnt); end
        @(negedge clk);
        rst = 1'b1;
        q.delete(); m_ovf = 0; m_dcnt = 0;
    endtask

    task automatic test_basic;
        byte unsigned exp;
        step(1, 8'h41, 0, 0); step(0, 0, 0, 0);
        step(1, 8'h42, 0, 0); step(0, 0, 0, 0);
        step(1, 8'h43, 0, 0);
        total++; if (count !== 5'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", count); end
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", rd_valid); end
        total++; if (rd_data !== 8'h41) begin bad++; $display("FAIL basic_head got=%h exp=41", rd_data); end
        for (int i = 0; i < 3; i++) begin
            exp = 8'h41 + byte'(i);
            total++; if (rd_data !== exp) begin bad++; $display("FAIL basic_read%0d got=%h exp=%h", i, rd_data, exp); end
            step(0, 0, 1, 0);
        end
        total++; if (empty !== 1'b1 || count !== 5'd0)
            begin bad++; $display("FAIL basic_drained empty=%b count=%0d exp empty=1 count=0", empty, count); end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 16; i++) step(1, byte'(i), 0, 0);
        step(1, 8'hAA, 0, 0);
        total++; if (full !== 1'b1)     begin bad++; $display("FAIL ovf_full got=%b exp=1", full); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL ovf_dcnt got=%0d exp=1", drop_cnt); end
        total++; if (count !== 5'd16)   begin bad++; $display("FAIL ovf_count got=%0d exp=16", count); end
        for (int i = 0; i < 16; i++) begin
            total++; if (rd_data !== byte'(i)) begin bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, rd_data, byte'(i)); end
            step(0, 0, 1, 0);
        end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL ovf_no_aa valid=%b exp=0", rd_valid); end
        step(0, 0, 0, 1);
        total++; if (overflow !== 1'b0 || drop_cnt !== 8'd0)
            begin bad++; $display("FAIL ovf_clear ovf=%b dcnt=%0d exp 0/0", overflow, drop_cnt); end
    endtask

    task automatic test_full_pop;
        for (int i = 0; i < 16; i++) step(1, byte'($urandom_range(0, 255)), 0, 0);
        step(1, 8'h55, 1, 0);
        total++; if (count !== 5'd16)   begin bad++; $display("FAIL fullpop_count got=%0d exp=16", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_ovf got=%b exp=0", overflow); end
        while (q.size() > 0) begin
            total++; if (rd_data !== q[0]) begin bad++; $display("FAIL fullpop_drain got=%h exp=%h", rd_data, q[0]); end
            step(0, 0, 1, 0);
        end
        total++; if (last_pop !== 8'h55 || empty !== 1'b1)
            begin bad++; $display("FAIL fullpop_last model_last=%h empty=%b exp 55/1", last_pop, empty); end
    endtask

    task automatic test_back_to_back;
        byte unsigned base, exp_next;
        int           n_read;
        base = byte'($urandom_range(0, 255));
        exp_next = base;
        n_read = 0;
        for (int i = 0; i <= 40; i++) begin
            if (rd_valid) begin
                total++; if (rd_data !== exp_next) begin bad++; $display("FAIL b2b_data%0d got=%h exp=%h", n_read, rd_data, exp_next); end
            end
            if (popped || i == 0) begin end
            step(i < 40, base + byte'(i), 1, 0);
            if (popped) begin exp_next++; n_read++; end
            total++; if (count > 5'd1 || count !== 5'(q.size()))
                begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", count, q.size()); end
        end
        total++; if (n_read !== 40 || empty !== 1'b1)
            begin bad++; $display("FAIL b2b_total reads=%0d empty=%b exp 40/1", n_read, empty); end
    endtask

    task automatic test_drop_sat;
        for (int i = 0; i < 16; i++) step(1, byte'(i + 3), 0, 0);
        for (int i = 0; i < 300; i++) step(1, byte'($urandom_range(0, 255)), 0, 0);
        total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_dcnt got=%0d exp=255", drop_cnt); end
        total++; if (overflow !== 1'b1)   begin bad++; $display("FAIL sat_ovf got=%b exp=1", overflow); end
        step(1, 8'h99, 0, 1);
        total++; if (overflow !== 1'b1 || drop_cnt !== 8'd1)
            begin bad++; $display("FAIL clr_drop ovf=%b dcnt=%0d exp 1/1", overflow, drop_cnt); end
        step(0, 0, 0, 1);
        total++; if (overflow !== 1'b0 || drop_cnt !== 8'd0)
            begin bad++; $display("FAIL clr_only ovf=%b dcnt=%0d exp 0/0", overflow, drop_cnt); end
        for (int i = 0; i < 16; i++) begin
            total++; if (rd_data !== byte'(i + 3)) begin bad++; $display("FAIL sat_drain%0d got=%h exp=%h", i, rd_data, byte'(i + 3)); end
            step(0, 0, 1, 0);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            if (q.size() > 0) begin
                total++; if (rd_data !== q[0]) begin bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, rd_data, q[0]); end
            end
            step($urandom_range(0, 99) < 60, byte'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
            total++;
            if (count !== 5'(q.size()) || full !== (q.size() == 16) || empty !== (q.size() == 0) ||
                rd_valid !== (q.size() != 0) || overflow !== m_ovf || drop_cnt !== 8'(m_dcnt)) begin
                bad++;
                $display("FAIL rand_state cyc=%0d count=%0d/%0d full=%b empty=%b valid=%b ovf=%b/%b dcnt=%0d/%0d",
                         i, count, q.size(), full, empty, rd_valid, overflow, m_ovf, drop_cnt, m_dcnt);
            end
        end
        while (q.size() > 0) step(0, 0, 1, 1);
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 5; i++) step(1, byte'(8'hC0 + i), 0, 0);
        total++; if (count !== 5'd5) begin bad++; $display("FAIL arst_pre count=%0d exp=5", count); end
        #2 rst = 1'b0;
        #1;
        total++; if (empty !== 1'b1 || count !== 5'd0 || rd_valid !== 1'b0)
            begin bad++; $display("FAIL arst_now empty=%b count=%0d valid=%b exp 1/0/0", empty, count, rd_valid); end
        q.delete(); m_ovf = 0; m_dcnt = 0;
        @(negedge clk);
        rst = 1'b1;
        step(1, 8'h77, 0, 0);
        total++; if (rd_valid !== 1'b1 || rd_data !== 8'h77 || count !== 5'd1)
            begin bad++; $display("FAIL arst_after valid=%b data=%h count=%0d exp 1/77/1", rd_valid, rd_data, count); end
        step(0, 0, 1, 0);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overflow;
        test_full_pop;
        test_back_to_back;
        test_drop_sat;
        test_random;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
